// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched
// Round-robin scheduler that shares one SPI master engine between NUM_REQ
// requesters. Each granted transfer goes through chip-select setup, the
// master start pulse, a wait for the master's done pulse (guarded by a
// watchdog), chip-select hold and an optional inter-frame gap. The received
// frame and a one-cycle completion pulse are returned to the served requester.

module spi_xfer_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int IDLE_GAP   = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_valid,
    output logic                          rsp_err,
    output logic                          m_start,
    output logic [DATA_WIDTH-1:0]         m_tx_data,
    input  logic                          m_done,
    input  logic [DATA_WIDTH-1:0]         m_rx_data,
    output logic [NUM_REQ-1:0]            ss_n,
    output logic                          busy
);

    // Zero setup/hold requests are stretched to one cycle so the chip select
    // always leads and trails the master activity by at least one clock.
    localparam int SETUP_CYC = (CS_SETUP < 1) ? 1 : CS_SETUP;
    localparam int HOLD_CYC  = (CS_HOLD  < 1) ? 1 : CS_HOLD;
    localparam int GAP_CYC   = (IDLE_GAP < 1) ? 1 : IDLE_GAP;

    localparam int CNT_MAX_SH = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int CNT_MAX    = (CNT_MAX_SH > GAP_CYC) ? CNT_MAX_SH : GAP_CYC;
    localparam int CNT_W      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int TMO_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int IDX_W      = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
    localparam bit               WDOG_EN    = (TIMEOUT > 0);
    localparam bit               GAP_EN     = (IDLE_GAP > 0);

    localparam logic [IDX_W:0]   NUM_REQ_W  = (IDX_W+1)'(NUM_REQ);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [CNT_W-1:0]      phase_cnt;
    logic [TMO_W-1:0]      xfer_cnt;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      cur_idx;
    logic                  err_pend;

    logic [2*NUM_REQ-1:0]  req_dbl;
    logic [NUM_REQ-1:0]    req_rot;
    logic [NUM_REQ-1:0]    rot_tmp;
    logic [IDX_W:0]        offset;
    logic [IDX_W:0]        idx_sum;
    logic [IDX_W:0]        ptr_sum;
    logic                  grant_found;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      ptr_nxt;
    logic [DATA_WIDTH-1:0] tx_sel;

    logic                  do_grant;
    logic                  setup_done;
    logic                  xfer_ok;
    logic                  xfer_tmo;
    logic                  hold_done;
    logic                  gap_done;

    // Rotate the request vector so the search starts at rr_ptr, take the
    // lowest set bit, then map the rotated offset back to a requester index.
    always_comb begin
        req_dbl     = {req, req};
        req_rot     = NUM_REQ'(req_dbl >> rr_ptr);
        rot_tmp     = req_rot;
        grant_found = 1'b0;
        offset      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && rot_tmp[0]) begin
                grant_found = 1'b1;
                offset      = (IDX_W+1)'(k);
            end
            rot_tmp = rot_tmp >> 1;
        end
        idx_sum = {1'b0, rr_ptr} + offset;
        if (idx_sum >= NUM_REQ_W) begin
            idx_sum = idx_sum - NUM_REQ_W;
        end
        grant_idx = idx_sum[IDX_W-1:0];
        ptr_sum   = {1'b0, grant_idx} + 1'b1;
        if (ptr_sum >= NUM_REQ_W) begin
            ptr_sum = '0;
        end
        ptr_nxt = ptr_sum[IDX_W-1:0];
        tx_sel  = DATA_WIDTH'(req_data >> (grant_idx * DATA_WIDTH));
    end

    // Phase-completion conditions; a done pulse in the expiry cycle wins over the watchdog.
    always_comb begin
        do_grant   = (state == S_IDLE)  && grant_found;
        setup_done = (state == S_SETUP) && (phase_cnt == SETUP_LAST);
        xfer_ok    = (state == S_XFER)  && m_done;
        xfer_tmo   = (state == S_XFER)  && !m_done && WDOG_EN && (xfer_cnt == TMO_LAST);
        hold_done  = (state == S_HOLD)  && (phase_cnt == HOLD_LAST);
        gap_done   = (state == S_GAP)   && (phase_cnt == GAP_LAST);
    end

    // Next-state selection for the transfer sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (do_grant)             state_nxt = S_SETUP;
            S_SETUP: if (setup_done)           state_nxt = S_XFER;
            S_XFER:  if (xfer_ok || xfer_tmo)  state_nxt = S_HOLD;
            S_HOLD:  if (hold_done)            state_nxt = GAP_EN ? S_GAP : S_IDLE;
            S_GAP:   if (gap_done)             state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Cycle counter for setup, hold and gap phases; restarts on every phase change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if (state_nxt != state) begin
            phase_cnt <= '0;
        end else if (state == S_SETUP || state == S_HOLD || state == S_GAP) begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    // Watchdog counter: number of XFER cycles already spent without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (state == S_XFER && state_nxt == S_XFER) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end else begin
            xfer_cnt <= '0;
        end
    end

    // Grant bookkeeping: served index, round-robin pointer and the latched tx frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_idx   <= '0;
            rr_ptr    <= '0;
            m_tx_data <= '0;
        end else if (do_grant) begin
            cur_idx   <= grant_idx;
            rr_ptr    <= ptr_nxt;
            m_tx_data <= tx_sel;
        end
    end

    // Chip selects: one line low from the grant edge until the hold phase ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n <= '1;
        end else if (do_grant) begin
            ss_n <= ~(NUM_REQ'(1) << grant_idx);
        end else if (hold_done) begin
            ss_n <= '1;
        end
    end

    // Master start pulse, aligned with the first XFER cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_start <= 1'b0;
        end else begin
            m_start <= setup_done;
        end
    end

    // Response capture: received frame on done, zero and a pending error on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            err_pend <= 1'b0;
        end else if (xfer_ok) begin
            rsp_data <= m_rx_data;
            err_pend <= 1'b0;
        end else if (xfer_tmo) begin
            rsp_data <= '0;
            err_pend <= 1'b1;
        end else if (hold_done) begin
            err_pend <= 1'b0;
        end
    end

    // Completion pulses, issued in the same cycle the chip select rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (hold_done) begin
            ack       <= NUM_REQ'(1) << cur_idx;
            rsp_valid <= 1'b1;
            rsp_err   <= err_pend;
        end else begin
            ack       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end
    end

    // Busy flag mirrors "not IDLE" for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb_spi_xfer_sched
// Directed bench for the SPI transfer scheduler: a behavioural SPI master
// answers each start pulse, and the main sequence walks through single
// transfers, round-robin order, pointer wrap, watchdog expiry, stray and
// late inputs, and a reset in the middle of a hold phase.

module tb_spi_xfer_sched;

    localparam int NR = 4;
    localparam int DW = 8;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    ack;
    logic [DW-1:0]    rsp_data;
    logic             rsp_valid;
    logic             rsp_err;
    logic             m_start;
    logic [DW-1:0]    m_tx_data;
    logic             m_done;
    logic [DW-1:0]    m_rx_data;
    logic [NR-1:0]    ss_n;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    int          master_delay = 3;
    bit          master_en    = 1'b1;
    bit          master_fixed = 1'b0;
    logic [7:0]  master_rx    = 8'h00;

    int cs_viol    = 0;
    int hi_run     = 0;
    int min_gap    = 1000;
    bit seen_frame = 1'b0;

    spi_xfer_sched #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .CS_SETUP   (2),
        .CS_HOLD    (2),
        .IDLE_GAP   (1),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .m_start   (m_start),
        .m_tx_data (m_tx_data),
        .m_done    (m_done),
        .m_rx_data (m_rx_data),
        .ss_n      (ss_n),
        .busy      (busy)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SPI master: done arrives in the master_delay-th cycle counting the start cycle.
    initial begin
        m_done    = 1'b0;
        m_rx_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m_start === 1'b1 && master_en) begin
                for (int k = 1; k < master_delay; k++) begin
                    @(posedge clk);
                    #1;
                end
                m_done    = 1'b1;
                m_rx_data = master_fixed ? master_rx : (m_tx_data ^ 8'hFF);
                @(posedge clk);
                #1;
                m_done    = 1'b0;
                m_rx_data = '0;
            end
        end
    end

    // Chip-select monitor: at most one line low, and the shortest all-high run between frames.
    always @(negedge clk) begin
        if (ss_n === 4'hF) begin
            hi_run = hi_run + 1;
        end else begin
            if (((~ss_n) & ((~ss_n) - 4'd1)) != 4'd0) cs_viol = cs_viol + 1;
            if (hi_run > 0 && seen_frame && hi_run < min_gap) min_gap = hi_run;
            hi_run     = 0;
            seen_frame = 1'b1;
        end
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR*DW-1:0] d);
        req      = r;
        req_data = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitAck(input int budget, output logic [NR-1:0] got);
        got = '0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (ack !== '0) begin
                got = ack;
                break;
            end
        end
    endtask

    task automatic waitStart(input int budget, output logic seen);
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (m_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    logic [NR-1:0] got;
    logic          seen;
    logic [7:0]    rr_vals [4];
    logic [NR-1:0] exp_onehot;

    // Directed test sequence.
    initial begin
        rr_vals[0] = 8'h11;
        rr_vals[1] = 8'h22;
        rr_vals[2] = 8'h33;
        rr_vals[3] = 8'h44;

        rst_n = 1'b0;
        applyStimulus(4'b0000, 32'h0);
        tick();
        tick();
        checkOutput("rst_ss_n",      32'(ss_n),      32'hF);
        checkOutput("rst_ack",       32'(ack),       32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_err",   32'(rsp_err),   32'h0);
        checkOutput("rst_m_start",   32'(m_start),   32'h0);
        checkOutput("rst_rsp_data",  32'(rsp_data),  32'h0);
        checkOutput("rst_m_tx_data", 32'(m_tx_data), 32'h0);
        checkOutput("rst_busy",      32'(busy),      32'h0);
        rst_n = 1'b1;
        tick();
        tick();

        $display("[TB] round-robin with all four requesters held");
        master_delay = 3;
        applyStimulus(4'b1111, 32'h44332211);
        for (int f = 0; f < 5; f++) begin
            waitAck(40, got);
            exp_onehot = 4'b0001 << (f % 4);
            checkOutput($sformatf("rr_ack%0d", f),  32'(got),      32'(exp_onehot));
            checkOutput($sformatf("rr_data%0d", f), 32'(rsp_data), 32'(rr_vals[f % 4] ^ 8'hFF));
            if (f == 4) req = 4'b0000;
        end
        repeat (3) tick();

        $display("[TB] single request with cycle-exact timing");
        master_fixed = 1'b1;
        master_rx    = 8'h3C;
        master_delay = 8;
        checkOutput("t1_idle_busy", 32'(busy), 32'h0);
        applyStimulus(4'b0010, 32'h4433A511);
        tick();
        checkOutput("t1_c1_ss_n",  32'(ss_n),      32'hD);
        checkOutput("t1_c1_busy",  32'(busy),      32'h1);
        checkOutput("t1_c1_tx",    32'(m_tx_data), 32'hA5);
        checkOutput("t1_c1_start", 32'(m_start),   32'h0);
        tick();
        checkOutput("t1_c2_start", 32'(m_start),   32'h0);
        tick();
        checkOutput("t1_c3_start", 32'(m_start),   32'h1);
        tick();
        checkOutput("t1_c4_start", 32'(m_start),   32'h0);
        repeat (8) tick();
        checkOutput("t1_c12_ack",  32'(ack),       32'h0);
        checkOutput("t1_c12_ss_n", 32'(ss_n),      32'hD);
        tick();
        checkOutput("t1_c13_ack",   32'(ack),       32'h2);
        checkOutput("t1_c13_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t1_c13_data",  32'(rsp_data),  32'h3C);
        checkOutput("t1_c13_err",   32'(rsp_err),   32'h0);
        checkOutput("t1_c13_ss_n",  32'(ss_n),      32'hF);
        req = 4'b0000;
        tick();
        checkOutput("t1_c14_ack",   32'(ack),       32'h0);
        checkOutput("t1_c14_valid", 32'(rsp_valid), 32'h0);
        checkOutput("t1_c14_busy",  32'(busy),      32'h0);
        master_fixed = 1'b0;
        master_delay = 3;
        repeat (2) tick();

        $display("[TB] pointer wrap");
        applyStimulus(4'b1000, 32'h44332211);
        waitAck(40, got);
        checkOutput("wrap_ack3",  32'(got),      32'h8);
        checkOutput("wrap_data3", 32'(rsp_data), 32'hBB);
        req = 4'b1001;
        waitAck(40, got);
        checkOutput("wrap_ack0_first", 32'(got),      32'h1);
        checkOutput("wrap_data0",      32'(rsp_data), 32'hEE);
        waitAck(40, got);
        checkOutput("wrap_ack3_next", 32'(got), 32'h8);
        req = 4'b0000;
        repeat (3) tick();

        $display("[TB] watchdog expiry");
        master_en = 1'b0;
        applyStimulus(4'b0100, 32'h44772211);
        waitStart(20, seen);
        checkOutput("tmo_start_seen", 32'(seen), 32'h1);
        repeat (17) tick();
        checkOutput("tmo_hold_ack",  32'(ack),  32'h0);
        checkOutput("tmo_hold_ss_n", 32'(ss_n), 32'hB);
        checkOutput("tmo_hold_busy", 32'(busy), 32'h1);
        tick();
        checkOutput("tmo_ack",   32'(ack),       32'h4);
        checkOutput("tmo_valid", 32'(rsp_valid), 32'h1);
        checkOutput("tmo_err",   32'(rsp_err),   32'h1);
        checkOutput("tmo_data",  32'(rsp_data),  32'h0);
        req = 4'b0000;
        tick();
        checkOutput("tmo_err_cleared", 32'(rsp_err), 32'h0);
        checkOutput("tmo_ack_cleared", 32'(ack),     32'h0);
        master_en = 1'b1;
        repeat (2) tick();
        applyStimulus(4'b0001, 32'h44772211);
        waitAck(40, got);
        checkOutput("post_tmo_ack",  32'(got),      32'h1);
        checkOutput("post_tmo_err",  32'(rsp_err),  32'h0);
        checkOutput("post_tmo_data", 32'(rsp_data), 32'hEE);
        req = 4'b0000;
        repeat (3) tick();

        $display("[TB] stray done and late input changes");
        m_done    = 1'b1;
        m_rx_data = 8'h99;
        tick();
        m_done    = 1'b0;
        m_rx_data = 8'h00;
        tick();
        checkOutput("stray_busy",  32'(busy),      32'h0);
        checkOutput("stray_ss_n",  32'(ss_n),      32'hF);
        checkOutput("stray_ack",   32'(ack),       32'h0);
        checkOutput("stray_valid", 32'(rsp_valid), 32'h0);
        checkOutput("stray_data",  32'(rsp_data),  32'hEE);
        master_delay = 6;
        applyStimulus(4'b1000, 32'h5C772211);
        waitStart(20, seen);
        checkOutput("late_start_seen", 32'(seen),      32'h1);
        checkOutput("late_tx_start",   32'(m_tx_data), 32'h5C);
        tick();
        applyStimulus(4'b0000, 32'hFF772211);
        tick();
        checkOutput("late_tx_after_change", 32'(m_tx_data), 32'h5C);
        checkOutput("late_busy",            32'(busy),      32'h1);
        waitAck(40, got);
        checkOutput("late_ack",  32'(got),      32'h8);
        checkOutput("late_data", 32'(rsp_data), 32'hA3);
        repeat (3) tick();

        $display("[TB] reset during hold");
        master_delay = 4;
        applyStimulus(4'b0010, 32'h44332211);
        waitStart(20, seen);
        checkOutput("rsth_start_seen", 32'(seen), 32'h1);
        repeat (4) tick();
        checkOutput("rsth_in_hold_busy", 32'(busy), 32'h1);
        checkOutput("rsth_in_hold_ss_n", 32'(ss_n), 32'hD);
        rst_n = 1'b0;
        #1;
        checkOutput("rsth_async_ss_n", 32'(ss_n), 32'hF);
        checkOutput("rsth_async_busy", 32'(busy), 32'h0);
        checkOutput("rsth_async_ack",  32'(ack),  32'h0);
        tick();
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();
        checkOutput("rsth_after_ack",  32'(ack),  32'h0);
        checkOutput("rsth_after_ss_n", 32'(ss_n), 32'hF);
        checkOutput("rsth_after_busy", 32'(busy), 32'h0);
        applyStimulus(4'b0110, 32'h44332211);
        waitAck(40, got);
        checkOutput("rsth_ptr_zero_ack1", 32'(got), 32'h2);
        req = 4'b0100;
        waitAck(40, got);
        checkOutput("rsth_ack2",  32'(got),      32'h4);
        checkOutput("rsth_data2", 32'(rsp_data), 32'hCC);
        req = 4'b0000;
        repeat (3) tick();

        checkOutput("cs_one_hot_violations", 32'(cs_viol), 32'h0);
        checkOutput("min_cs_gap",            32'(min_gap), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
